// File: rtl/trig_counter_fsm.sv
// Trigger-started counter with a programmable limit, up/down direction and one-shot/reload modes.
// Every output is registered; there is no combinational path from any input to an output.
module trig_counter_fsm #(
    parameter int WIDTH           = 4,
    parameter int ALLOW_RETRIGGER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir_down,
    input  logic             mode_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] lim_q, lim_n;
    logic             dir_q, dir_n;
    logic             mode_q, mode_n;
    logic [WIDTH-1:0] out_n;
    logic             busy_n, tc_n;
    logic [WIDTH-1:0] term_val, start_val, step_val;
    logic             accept;

    assign term_val  = dir_q ? '0 : lim_q;
    assign start_val = dir_q ? lim_q : '0;
    assign step_val  = dir_q ? out - WIDTH'(1) : out + WIDTH'(1);
    assign accept    = trigger && ((state == IDLE) || (ALLOW_RETRIGGER != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lim_q  <= '0;
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
            out    <= '0;
            busy   <= 1'b0;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            lim_q  <= lim_n;
            dir_q  <= dir_n;
            mode_q <= mode_n;
            out    <= out_n;
            busy   <= busy_n;
            tc     <= tc_n;
        end
    end

    // tc is computed from the next count so it lines up with the cycle out holds the terminal value.
    always_comb begin
        state_n = state;
        lim_n   = lim_q;
        dir_n   = dir_q;
        mode_n  = mode_q;
        out_n   = out;
        busy_n  = busy;
        tc_n    = 1'b0;
        if (abort) begin
            state_n = IDLE;
            out_n   = '0;
            busy_n  = 1'b0;
        end else if (accept) begin
            lim_n   = load_val;
            dir_n   = dir_down;
            mode_n  = mode_reload;
            state_n = RUN;
            out_n   = dir_down ? load_val : '0;
            busy_n  = 1'b1;
            tc_n    = (load_val == '0);
        end else if (state == RUN) begin
            if (out != term_val) begin
                out_n = step_val;
                tc_n  = (step_val == term_val);
            end else if (mode_q) begin
                out_n = start_val;
                tc_n  = (lim_q == '0);
            end else begin
                state_n = IDLE;
                out_n   = '0;
                busy_n  = 1'b0;
            end
        end else begin
            out_n  = '0;
            busy_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_trig_counter_fsm.sv
// Directed bench: one retriggerable and one non-retriggerable instance share the stimulus.
// Both are checked wherever the retrigger policy does not matter.
module tb_trig_counter_fsm;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         trigger, abort, dir_down, mode_reload;
    logic [W-1:0] load_val;
    logic [W-1:0] out_rt, out_nr;
    logic         busy_rt, busy_nr, tc_rt, tc_nr;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    trig_counter_fsm #(.WIDTH(W), .ALLOW_RETRIGGER(1)) dut_rt (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .load_val(load_val),
        .dir_down(dir_down), .mode_reload(mode_reload), .out(out_rt), .busy(busy_rt), .tc(tc_rt)
    );

    trig_counter_fsm #(.WIDTH(W), .ALLOW_RETRIGGER(0)) dut_nr (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .load_val(load_val),
        .dir_down(dir_down), .mode_reload(mode_reload), .out(out_nr), .busy(busy_nr), .tc(tc_nr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic exp_rt(input string tag, input int o, input int b, input int t);
        chk({tag, ".rt.out"}, 32'(out_rt), 32'(o));
        chk({tag, ".rt.busy"}, 32'(busy_rt), 32'(b));
        chk({tag, ".rt.tc"}, 32'(tc_rt), 32'(t));
    endtask

    task automatic exp_nr(input string tag, input int o, input int b, input int t);
        chk({tag, ".nr.out"}, 32'(out_nr), 32'(o));
        chk({tag, ".nr.busy"}, 32'(busy_nr), 32'(b));
        chk({tag, ".nr.tc"}, 32'(tc_nr), 32'(t));
    endtask

    task automatic exp_both(input string tag, input int o, input int b, input int t);
        exp_rt(tag, o, b, t);
        exp_nr(tag, o, b, t);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int lim, input logic dn, input logic rl);
        load_val    = W'(lim);
        dir_down    = dn;
        mode_reload = rl;
        trigger     = 1'b1;
        step();
        trigger     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trigger = 1'b0; abort = 1'b0;
        load_val = '0; dir_down = 1'b0; mode_reload = 1'b0;
        #12;
        exp_both("reset", 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        step();
        exp_both("idle", 0, 0, 0);

        // 1: asynchronous reset mid-run
        start(9, 1'b0, 1'b0);
        exp_both("t1.start", 0, 1, 0);
        repeat (4) step();
        exp_both("t1.at4", 4, 1, 0);
        #2 rst = 1'b1;
        #1 exp_both("t1.async", 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        step(); step();
        exp_both("t1.after", 0, 0, 0);

        // 2: one-shot up, limit 5
        start(5, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            exp_both($sformatf("t2.c%0d", i), i, 1, (i == 5) ? 1 : 0);
            step();
        end
        exp_both("t2.end", 0, 0, 0);

        // 3: one-shot down, limit 3, then limit 0
        start(3, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            exp_both($sformatf("t3.c%0d", i), i, 1, (i == 0) ? 1 : 0);
            step();
        end
        exp_both("t3.end", 0, 0, 0);
        start(0, 1'b0, 1'b0);
        exp_both("t3.lim0", 0, 1, 1);
        step();
        exp_both("t3.lim0end", 0, 0, 0);

        // 4: auto-reload, limit 2, nine cycles
        start(2, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            exp_both($sformatf("t4.c%0d", i), i % 3, 1, (i % 3 == 2) ? 1 : 0);
            step();
        end
        abort = 1'b1; step(); abort = 1'b0;
        exp_both("t4.abort", 0, 0, 0);

        // 5: abort wins over trigger
        start(9, 1'b0, 1'b0);
        repeat (3) step();
        exp_both("t5.at3", 3, 1, 0);
        abort = 1'b1; trigger = 1'b1; load_val = W'(2);
        step();
        abort = 1'b0; trigger = 1'b0;
        exp_both("t5.abort", 0, 0, 0);
        step();
        exp_both("t5.idle", 0, 0, 0);
        start(2, 1'b0, 1'b0);
        for (int i = 0; i <= 2; i++) begin
            exp_both($sformatf("t5.c%0d", i), i, 1, (i == 2) ? 1 : 0);
            step();
        end
        exp_both("t5.end", 0, 0, 0);

        // 6: retrigger at out=4 of a limit-7 run with load_val=2
        start(7, 1'b0, 1'b0);
        repeat (4) step();
        exp_both("t6.at4", 4, 1, 0);
        load_val = W'(2); trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_rt($sformatf("t6.c%0d", i), i, 1, (i == 2) ? 1 : 0);
            exp_nr($sformatf("t6.c%0d", i), 5 + i, 1, (i == 2) ? 1 : 0);
            step();
        end
        exp_both("t6.end", 0, 0, 0);

        // Trigger in the terminal cycle of a one-shot run
        start(1, 1'b0, 1'b0);
        step();
        exp_both("t7.term", 1, 1, 1);
        load_val = W'(1); trigger = 1'b1;
        step();
        trigger = 1'b0;
        exp_rt("t7.restart", 0, 1, 0);
        exp_nr("t7.ignored", 0, 0, 0);
        step();
        exp_rt("t7.c1", 1, 1, 1);
        exp_nr("t7.idle", 0, 0, 0);
        step();
        exp_both("t7.end", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
